// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundle of the fetch unit's control-unit, instruction-memory
//                and IF/ID signals. The master view belongs to the fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        stall;
    logic        branch;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        fetch_timeout;

    // Fetch unit side
    modport master (
        input  stall, branch, branch_target, imem_ack, imem_rdata,
        output imem_req, imem_addr, if_instr, id_instr, id_pc4, id_valid,
               fetch_timeout
    );

    // Control unit / memory / pipeline side
    modport slave (
        output stall, branch, branch_target, imem_ack, imem_rdata,
        input  imem_req, imem_addr, if_instr, id_instr, id_pc4, id_valid,
               fetch_timeout
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage with IF/ID register. Zero-latency
//                delivery on ack, HOLD state to park a word during stall,
//                single delay-slot branch handling with a pending target.
//                Optional fetch timeout flag enabled by FETCH_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    fetch_unit_if.master  bus
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pend_v;
    logic [31:0] r_pend_t;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_pend_v_nxt;
    logic [31:0] w_pend_t_nxt;
    logic [31:0] w_id_instr_nxt;
    logic [31:0] w_id_pc4_nxt;
    logic        w_id_valid_nxt;
    logic [31:0] w_hold_instr_nxt;
    logic [31:0] w_hold_pc_nxt;

    logic        w_req;
    logic        w_ack;
    logic [31:0] w_redirect;

    // Request is suppressed while reset is held so nothing is issued before release
    assign w_req = (r_state == FETCH) && rst_n;
    // Ack without an outstanding request carries no data
    assign w_ack = w_req && bus.imem_ack;

    // Address following a delivered word: accepted branch, then pending target, then sequential
    assign w_redirect = (bus.branch && !bus.stall) ? bus.branch_target :
                        r_pend_v                   ? r_pend_t          :
                                                     r_pc + 32'd4;

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc;
    assign bus.if_instr  = (r_state == HOLD) ? r_hold_instr :
                           w_ack             ? bus.imem_rdata : 32'h0;
    assign bus.id_instr  = r_id_instr;
    assign bus.id_pc4    = r_id_pc4;
    assign bus.id_valid  = r_id_valid;

    // Next-state, PC, pending branch and IF/ID update
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_v_nxt     = r_pend_v;
        w_pend_t_nxt     = r_pend_t;
        w_id_instr_nxt   = r_id_instr;
        w_id_pc4_nxt     = r_id_pc4;
        w_id_valid_nxt   = r_id_valid;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc_nxt    = r_hold_pc;
        case (r_state)
            FETCH: begin
                if (w_ack) begin
                    if (!bus.stall) begin
                        // Word goes straight to ID; it is the delay slot if a branch is accepted now
                        w_id_instr_nxt = bus.imem_rdata;
                        w_id_pc4_nxt   = r_pc + 32'd4;
                        w_id_valid_nxt = 1'b1;
                        w_pc_nxt       = w_redirect;
                        w_pend_v_nxt   = 1'b0;
                    end else begin
                        // ID is frozen: park the word and stop requesting
                        w_hold_instr_nxt = bus.imem_rdata;
                        w_hold_pc_nxt    = r_pc;
                        w_state_nxt      = HOLD;
                    end
                end else if (!bus.stall) begin
                    // Bubble into ID; a branch seen now waits for its delay slot
                    w_id_instr_nxt = 32'h0;
                    w_id_valid_nxt = 1'b0;
                    if (bus.branch) begin
                        w_pend_v_nxt = 1'b1;
                        w_pend_t_nxt = bus.branch_target;
                    end
                end
            end
            HOLD: begin
                if (!bus.stall) begin
                    w_id_instr_nxt = r_hold_instr;
                    w_id_pc4_nxt   = r_hold_pc + 32'd4;
                    w_id_valid_nxt = 1'b1;
                    w_pc_nxt       = w_redirect;
                    w_pend_v_nxt   = 1'b0;
                    w_state_nxt    = FETCH;
                end
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_pend_v     <= 1'b0;
            r_pend_t     <= 32'h0;
            r_id_instr   <= 32'h0;
            r_id_pc4     <= 32'h0;
            r_id_valid   <= 1'b0;
            r_hold_instr <= 32'h0;
            r_hold_pc    <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend_v     <= w_pend_v_nxt;
            r_pend_t     <= w_pend_t_nxt;
            r_id_instr   <= w_id_instr_nxt;
            r_id_pc4     <= w_id_pc4_nxt;
            r_id_valid   <= w_id_valid_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYC);

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [c_CNT_W-1:0] w_wait_inc;
    logic               r_timeout;

    assign w_wait_inc = r_wait_cnt + 1'b1;

    // Count unanswered request cycles; the flag is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_ack) begin
                r_wait_cnt <= '0;
            end else if (w_req && (r_wait_cnt != c_LIMIT)) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc == c_LIMIT) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign bus.fetch_timeout = r_timeout;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = |TIMEOUT_CYC;
    assign bus.fetch_timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

`ifdef FETCH_TIMEOUT_EN
    localparam logic c_TO_EN = 1'b1;
`else
    localparam logic c_TO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; leave 1 time unit after the edge before touching anything
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] tgt,
                         input logic a, input logic [31:0] rd);
        bus.stall         = s;
        bus.branch        = b;
        bus.branch_target = tgt;
        bus.imem_ack      = a;
        bus.imem_rdata    = rd;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 0, 32'h0, 1, 32'hAAAA_5555);
        tick();
        tick();
        // Reset state, with a stray ack present
        check("rst_req",      {31'h0, bus.imem_req},      32'h0);
        check("rst_id_instr", bus.id_instr,               32'h0);
        check("rst_id_pc4",   bus.id_pc4,                 32'h0);
        check("rst_id_valid", {31'h0, bus.id_valid},      32'h0);
        check("rst_if_instr", bus.if_instr,               32'h0);
        check("rst_timeout",  {31'h0, bus.fetch_timeout}, 32'h0);

        // Back-to-back zero-latency fetches
        rst_n = 1'b1;
        drive(0, 0, 32'h0, 1, 32'h2001_0001);
        check("f0_req",      {31'h0, bus.imem_req}, 32'h1);
        check("f0_addr",     bus.imem_addr,         32'h0);
        check("f0_if_instr", bus.if_instr,          32'h2001_0001);
        tick();
        check("f0_id_instr", bus.id_instr,          32'h2001_0001);
        check("f0_id_pc4",   bus.id_pc4,            32'h4);
        check("f0_id_valid", {31'h0, bus.id_valid}, 32'h1);
        drive(0, 0, 32'h0, 1, 32'h2002_0002);
        check("f1_addr",     bus.imem_addr,         32'h4);
        tick();
        check("f1_id_instr", bus.id_instr,          32'h2002_0002);
        check("f1_id_pc4",   bus.id_pc4,            32'h8);

        // Stall with ack at 0x8: word parked in HOLD
        drive(1, 0, 32'h0, 1, 32'h2003_0003);
        check("h_addr", bus.imem_addr, 32'h8);
        tick();
        drive(1, 0, 32'h0, 1, 32'hDEAD_BEEF);
        check("h1_req",      {31'h0, bus.imem_req}, 32'h0);
        check("h1_if_instr", bus.if_instr,          32'h2003_0003);
        check("h1_id_instr", bus.id_instr,          32'h2002_0002);
        tick();
        check("h2_id_instr", bus.id_instr,          32'h2002_0002);
        check("h2_id_pc4",   bus.id_pc4,            32'h8);
        drive(0, 0, 32'h0, 0, 32'h0);
        check("h3_if_instr", bus.if_instr,          32'h2003_0003);
        tick();
        check("h3_id_instr", bus.id_instr,          32'h2003_0003);
        check("h3_id_pc4",   bus.id_pc4,            32'hC);
        check("h3_id_valid", {31'h0, bus.id_valid}, 32'h1);
        check("h3_addr",     bus.imem_addr,         32'hC);
        check("h3_req",      {31'h0, bus.imem_req}, 32'h1);

        // Branch accepted with a word delivered: that word is the delay slot
        drive(0, 0, 32'h0, 1, 32'h2004_0004);
        tick();
        drive(0, 1, 32'h100, 1, 32'h2005_0005);
        check("b1_addr",     bus.imem_addr,         32'h10);
        tick();
        check("b1_id_instr", bus.id_instr,          32'h2005_0005);
        check("b1_id_pc4",   bus.id_pc4,            32'h14);

        // Branch accepted without a word: bubble, then delay slot, then target
        drive(0, 1, 32'h200, 0, 32'h0);
        check("b2_addr",     bus.imem_addr,         32'h100);
        tick();
        check("b2_id_instr", bus.id_instr,          32'h0);
        check("b2_id_valid", {31'h0, bus.id_valid}, 32'h0);
        check("b2_id_pc4",   bus.id_pc4,            32'h14);
        drive(0, 0, 32'h0, 1, 32'h2006_0006);
        check("b2_addr_stable", bus.imem_addr,      32'h100);
        tick();
        check("b2_ds_instr", bus.id_instr,          32'h2006_0006);
        check("b2_ds_pc4",   bus.id_pc4,            32'h104);
        check("b2_ds_valid", {31'h0, bus.id_valid}, 32'h1);

        // Branch during stall is ignored, nothing moves
        drive(1, 1, 32'h300, 0, 32'h0);
        check("b3_addr",     bus.imem_addr,         32'h200);
        tick();
        check("b3_id_instr", bus.id_instr,          32'h2006_0006);
        check("b3_id_valid", {31'h0, bus.id_valid}, 32'h1);
        drive(0, 0, 32'h0, 1, 32'h2007_0007);
        check("b3_addr_hold", bus.imem_addr,        32'h200);
        tick();
        check("b3_id_pc4",   bus.id_pc4,            32'h204);

        // Second pending branch overwrites the first
        drive(0, 1, 32'h400, 0, 32'h0);
        tick();
        drive(0, 1, 32'h500, 0, 32'h0);
        tick();
        drive(0, 0, 32'h0, 1, 32'h2008_0008);
        check("b4_addr",     bus.imem_addr,         32'h204);
        tick();
        check("b4_id_instr", bus.id_instr,          32'h2008_0008);
        check("b4_id_pc4",   bus.id_pc4,            32'h208);
        drive(0, 0, 32'h0, 0, 32'h0);
        check("b4_target",   bus.imem_addr,         32'h500);

        // Sequential wrap at the top of the address space
        drive(0, 1, 32'hFFFF_FFFC, 1, 32'h2009_0009);
        tick();
        check("w_id_pc4",    bus.id_pc4,            32'h504);
        drive(0, 0, 32'h0, 1, 32'h200A_000A);
        check("w_addr_top",  bus.imem_addr,         32'hFFFF_FFFC);
        tick();
        check("w_id_instr",  bus.id_instr,          32'h200A_000A);
        check("w_id_pc4_0",  bus.id_pc4,            32'h0);
        drive(0, 0, 32'h0, 0, 32'h0);
        check("w_addr_0",    bus.imem_addr,         32'h0);

        // Withheld ack: flag after the 16th unanswered cycle, sticky after ack resumes
        for (int i = 0; i < 15; i++) tick();
        check("t15_timeout", {31'h0, bus.fetch_timeout}, 32'h0);
        check("t15_valid",   {31'h0, bus.id_valid},      32'h0);
        check("t15_addr",    bus.imem_addr,              32'h0);
        tick();
        check("t16_timeout", {31'h0, bus.fetch_timeout}, {31'h0, c_TO_EN});
        drive(0, 0, 32'h0, 1, 32'h200C_000C);
        tick();
        check("t_sticky",    {31'h0, bus.fetch_timeout}, {31'h0, c_TO_EN});
        check("t_id_instr",  bus.id_instr,               32'h200C_000C);

        // Reset asserted while in HOLD
        drive(1, 0, 32'h0, 1, 32'h200B_000B);
        tick();
        check("r_hold_req",  {31'h0, bus.imem_req},      32'h0);
        rst_n = 1'b0;
        #1;
        check("r_req",       {31'h0, bus.imem_req},      32'h0);
        check("r_id_instr",  bus.id_instr,               32'h0);
        check("r_id_pc4",    bus.id_pc4,                 32'h0);
        check("r_id_valid",  {31'h0, bus.id_valid},      32'h0);
        check("r_if_instr",  bus.if_instr,               32'h0);
        check("r_timeout",   {31'h0, bus.fetch_timeout}, 32'h0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0);
        check("r_rel_req",   {31'h0, bus.imem_req},      32'h1);
        check("r_rel_addr",  bus.imem_addr,              32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
